// File: rtl/param_sequence_detector.sv
// Parametrised Mealy serial-pattern detector with loadable pattern, bit-valid qualifier
// and selectable overlap. Define MATCH_COUNT_EN to build the saturating match counter.
//
// state (fill_q) | meaning
// S0             | no history since reset/load/non-overlapped match
// Sk             | k valid bits held in hist_q
// S(LEN-1)       | history full; next valid bit can complete a match
module param_sequence_detector #(
  parameter int                     PATTERN_LEN   = 4,
  parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = 4'b1011,
  parameter int                     OVERLAP       = 1,
  parameter int                     CNT_W         = 8
) (
  input  logic                   i_Clk,
  input  logic                   Reset,
  input  logic                   i_Valid,
  input  logic                   Sequence,
  input  logic                   i_Load,
  input  logic [PATTERN_LEN-1:0] i_Pattern,
  output logic                   X,
  output logic                   o_Match_Reg,
  output logic [CNT_W-1:0]       o_Count
);

  localparam int FW = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;
  localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [PATTERN_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [PATTERN_LEN-1:0] window;

  // window is the candidate pattern: stored history plus the bit arriving now
  assign window = {hist_q, Sequence};
  assign X = i_Valid & ~i_Load & ~Reset & (fill_q == FULL) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (i_Load) begin
      pat_d  = i_Pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (i_Valid) begin
      if (X && (OVERLAP == 0)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PATTERN_LEN-2:0];
        fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      pat_q       <= RESET_PATTERN;
      hist_q      <= '0;
      fill_q      <= '0;
      o_Match_Reg <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      o_Match_Reg <= X;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // saturates rather than wrapping; i_Load deliberately leaves it alone
  always_ff @(posedge i_Clk) begin
    if (Reset)
      cnt_q <= '0;
    else if (X && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign o_Count = cnt_q;
`else
  assign o_Count = '0;
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Scoreboard bench for param_sequence_detector: one overlapping and one non-overlapping
// instance share stimulus; a bit-history reference model predicts every output each cycle.
module tb_param_sequence_detector;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [N-1:0] RST_PAT = 4'b1011;

  logic          i_Clk = 1'b0;
  logic          Reset = 1'b1, i_Valid = 1'b0, Sequence = 1'b0, i_Load = 1'b0;
  logic [N-1:0]  i_Pattern = '0;
  logic          x1, x0, mr1, mr0;
  logic [CW-1:0] cnt1, cnt0;

  param_sequence_detector #(.PATTERN_LEN(N), .RESET_PATTERN(RST_PAT), .OVERLAP(1), .CNT_W(CW)) dut_ov (
    .i_Clk(i_Clk), .Reset(Reset), .i_Valid(i_Valid), .Sequence(Sequence), .i_Load(i_Load),
    .i_Pattern(i_Pattern), .X(x1), .o_Match_Reg(mr1), .o_Count(cnt1));

  param_sequence_detector #(.PATTERN_LEN(N), .RESET_PATTERN(RST_PAT), .OVERLAP(0), .CNT_W(CW)) dut_no (
    .i_Clk(i_Clk), .Reset(Reset), .i_Valid(i_Valid), .Sequence(Sequence), .i_Load(i_Load),
    .i_Pattern(i_Pattern), .X(x0), .o_Match_Reg(mr0), .o_Count(cnt0));

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [1:0] x;
    logic [1:0] mreg;
    int         cnt1;
    int         cnt0;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // reference model: all valid bits received since the last clear, newest in LSB
  logic [N-1:0] m_pat;
  logic [63:0]  m_bits [2];
  int           m_nb   [2];
  int           m_cnt  [2];
  logic         m_prev [2];

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge i_Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("x_overlap",      int'(x1),   int'(e.x[1]));
      chk("x_nonoverlap",   int'(x0),   int'(e.x[0]));
      chk("mreg_overlap",   int'(mr1),  int'(e.mreg[1]));
      chk("mreg_nonoverlap", int'(mr0), int'(e.mreg[0]));
      chk("count_overlap",  int'(cnt1), e.cnt1);
      chk("count_nonoverlap", int'(cnt0), e.cnt0);
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic s, input logic ld,
                     input logic [N-1:0] p, input bit push = 1'b1);
    exp_t e;
    logic [63:0] nb;
    logic xe;
    @(posedge i_Clk);
    #1;
    Reset = rst; i_Valid = v; Sequence = s; i_Load = ld; i_Pattern = p;
    for (int i = 0; i < 2; i++) begin
      nb = {m_bits[i][62:0], s};
      xe = !rst && !ld && v && (m_nb[i] + 1 >= N) && (nb[N-1:0] == m_pat);
      e.x[i]    = xe;
      e.mreg[i] = m_prev[i];
      if (i == 1) e.cnt1 = m_cnt[i]; else e.cnt0 = m_cnt[i];
      if (rst) begin
        m_bits[i] = '0; m_nb[i] = 0; m_cnt[i] = 0;
      end else if (ld) begin
        m_bits[i] = '0; m_nb[i] = 0;
      end else if (v) begin
        if (xe && i == 0) begin
          m_bits[i] = '0; m_nb[i] = 0;
        end else begin
          m_bits[i] = nb; m_nb[i] = m_nb[i] + 1;
        end
      end
`ifdef MATCH_COUNT_EN
      if (xe && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
`endif
      m_prev[i] = xe;
    end
    if (rst) m_pat = RST_PAT;
    else if (ld) m_pat = p;
    if (push) sb.push_back(e);
  endtask

  task automatic bits(input logic [15:0] b, input int n);
    for (int k = n - 1; k >= 0; k--) cyc(1'b0, 1'b1, b[k], 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_bits[i] = '0; m_nb[i] = 0; m_cnt[i] = 0; m_prev[i] = 1'b0;
    end
    m_pat = RST_PAT;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
    // T1: 0,1,0,1,1,0,1,1 on reset pattern
    bits(16'b01011011, 8);
    // T2: pattern 1010, stream 1,0,1,0,1,0
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    bits(16'b101010, 6);
    // T3: pattern 1011 with valid gaps
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
    bits(16'b10, 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    bits(16'b11, 2);
    // T4: partial pattern then reset mid-stream
    bits(16'b101, 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
    bits(16'b1, 1);
    bits(16'b1011, 4);
    // T5: load 0110 mid-stream (bit in load cycle discarded), then old pattern
    bits(16'b10, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110);
    bits(16'b0110, 4);
    bits(16'b1011, 4);
    // T6-ish: repeated matches to reach counter saturation
    bits(16'b0110, 4);
    bits(16'b0110, 4);
    bits(16'b0110110, 7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic r, v, l;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      cyc(r, v, 1'($urandom), l, ($urandom_range(0, 3) == 0) ? 4'b1011 : N'($urandom));
    end
    @(posedge i_Clk);
    #1;
    Reset = 1'b0; i_Valid = 1'b0; i_Load = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
